rsc_encoder: RTL and testbench
==============================

RSC_ENCODER -- requirements
Module: rsc_encoder

Interface
REQ-001 SHALL provide parameter AMP, default 16'sd64: symbol magnitude driven on out.
REQ-002 SHALL provide port clk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL provide port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL provide port start  input  1  one-cycle pulse that begins a block; sampled only in IDLE.
REQ-005 SHALL provide port blklen  input  16  block length in information bits (1..65535); sampled when start is accepted.
REQ-006 SHALL provide port bit_in  input  1  information bit.
REQ-007 SHALL provide port valid_in  input  1  bit_in qualifier.
REQ-008 SHALL provide port ready_in  output  1  high when a bit is accepted this cycle if valid_in is high.
REQ-009 SHALL provide port out  output  16  signed soft symbol: sys and parity symbols interleaved, sys first.
REQ-010 SHALL provide port valid_out  output  1  out qualifier.
REQ-011 SHALL provide port last_out  output  1  high with the final tail parity symbol only.
REQ-012 SHALL provide port busy  output  1  high in every state except IDLE.

Function
REQ-013 SHALL implement an 8-state FSM-driven RSC encoder with states IDLE, ENCODE, TAIL.
REQ-014 Trellis: registers s1,s2,s3 (s1 newest); feedback a = u^s2^s3; parity z = a^s1^s3; update s3<=s2, s2<=s1, s1<=a (g0=13, g1=15 octal).
REQ-015 IDLE: start=1 with blklen!=0 SHALL latch blklen, clear s1..s3, clear the bit counter, clear phase and go to ENCODE; start with blklen=0 SHALL be ignored.
REQ-016 ready_in SHALL be 1 only in ENCODE with phase=0 (sys slot); a bit is accepted on valid_in&ready_in.
REQ-017 Accepted bit at cycle n: sys symbol on out at n+1, parity symbol at n+2, both with valid_out=1; phase=1 at n+1 forces ready_in=0.
REQ-018 Back-to-back acceptance (at n, n+2, ...) SHALL yield a gap-free output stream; valid_in low in a sys slot SHALL yield valid_out=0 until the next acceptance's sys symbol.
REQ-019 Mapping: bit 0 -> +AMP, bit 1 -> -AMP, two's complement 16-bit.
REQ-020 After the parity of the blklen-th bit is issued, the FSM SHALL enter TAIL in the following cycle with no idle gap and ready_in=0.
REQ-021 TAIL SHALL run 3 steps with u = s2^s3 (forcing a=0), each emitting sys u then parity z on consecutive cycles, 6 symbols in total, contiguous.
REQ-022 last_out SHALL be 1 with the 6th tail symbol; the FSM SHALL return to IDLE the next cycle with s1..s3 = 0.
REQ-023 Symbols per block SHALL be 2*blklen+6; the bit counter SHALL be 16-bit and SHALL NOT wrap for blklen=65535.
REQ-024 start while busy SHALL be ignored, with no effect on the block in progress.
REQ-025 valid_in while ready_in=0 SHALL be ignored; the source holds bit_in until accepted.
REQ-026 No output backpressure; consumer SHALL accept every valid_out cycle.

Reset
REQ-027 rst=1 SHALL, at the next edge, force IDLE, s1..s3=0, counter=0, phase=0, out=0, valid_out=0, last_out=0, ready_in=0, busy=0.
REQ-028 rst mid-block SHALL abort the block without emitting tail symbols; the next start SHALL encode from the zero state.
REQ-029 rst SHALL take priority over start and valid_in in the same cycle.

Verification
REQ-030 blklen=3, bits 1,0,0 back-to-back, AMP=64 -> 12 contiguous symbols: -64,-64, +64,-64, +64,-64, -64,+64, -64,+64, -64,-64; last_out on the 12th only.
REQ-031 blklen=4, all-zero bits -> 14 symbols all +64; final state zero; busy drops the cycle after last_out.
REQ-032 blklen=3, bits 1,0,0 with valid_in low for 3 cycles between bits -> same symbol sequence as REQ-030, with valid_out gaps; ready_in never 1 in a parity slot.
REQ-033 start pulse mid-block and start with blklen=0 in IDLE -> no change in output, busy unaffected.
REQ-034 rst asserted after the 2nd accepted bit of blklen=8 -> all outputs 0 the next cycle; new block blklen=3 with bits 1,0,0 reproduces REQ-030 exactly.
REQ-035 Random blocks, blklen 1..6144 -> output matches golden LTE RSC model; final state zero; 2*blklen+6 symbols.

Source files
------------

// File: rtl/rsc_encoder.sv
// Recursive systematic convolutional encoder (g0=13, g1=15 octal) with 3-step trellis termination.
// Emits one antipodal soft symbol per cycle: sys then parity for each bit, then 6 tail symbols.
module rsc_encoder #(
    parameter logic signed [15:0] AMP = 16'sd64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [15:0]        blklen,
    input  logic               bit_in,
    input  logic               valid_in,
    output logic               ready_in,
    output logic signed [15:0] out,
    output logic               valid_out,
    output logic               last_out,
    output logic               busy
);

    typedef enum logic [1:0] {IDLE, ENCODE, TAIL} state_t;

    state_t             state, state_nx;
    logic               phase, phase_nx;
    logic               s1, s2, s3, s1_nx, s2_nx, s3_nx;
    logic               par, par_nx;
    logic [15:0]        cnt, cnt_nx;
    logic [15:0]        len, len_nx;
    logic [1:0]         tcnt, tcnt_nx;
    logic signed [15:0] out_nx;
    logic               valid_nx, last_nx;
    logic               fb, tu;

    function automatic logic signed [15:0] sym(input logic b);
        return b ? -AMP : AMP;
    endfunction

    assign ready_in = (state == ENCODE) && !phase;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            phase     <= 1'b0;
            s1        <= 1'b0;
            s2        <= 1'b0;
            s3        <= 1'b0;
            par       <= 1'b0;
            cnt       <= '0;
            len       <= '0;
            tcnt      <= '0;
            out       <= '0;
            valid_out <= 1'b0;
            last_out  <= 1'b0;
        end else begin
            state     <= state_nx;
            phase     <= phase_nx;
            s1        <= s1_nx;
            s2        <= s2_nx;
            s3        <= s3_nx;
            par       <= par_nx;
            cnt       <= cnt_nx;
            len       <= len_nx;
            tcnt      <= tcnt_nx;
            out       <= out_nx;
            valid_out <= valid_nx;
            last_out  <= last_nx;
        end
    end

    always_comb begin
        state_nx = state;
        phase_nx = phase;
        s1_nx    = s1;
        s2_nx    = s2;
        s3_nx    = s3;
        par_nx   = par;
        cnt_nx   = cnt;
        len_nx   = len;
        tcnt_nx  = tcnt;
        out_nx   = '0;
        valid_nx = 1'b0;
        last_nx  = 1'b0;
        fb       = bit_in ^ s2 ^ s3;
        tu       = s2 ^ s3;
        case (state)
            IDLE: begin
                if (start && blklen != 16'd0) begin
                    len_nx   = blklen;
                    s1_nx    = 1'b0;
                    s2_nx    = 1'b0;
                    s3_nx    = 1'b0;
                    cnt_nx   = '0;
                    tcnt_nx  = '0;
                    phase_nx = 1'b0;
                    state_nx = ENCODE;
                end
            end
            ENCODE: begin
                if (!phase) begin
                    if (valid_in) begin
                        out_nx   = sym(bit_in);
                        valid_nx = 1'b1;
                        par_nx   = fb ^ s1 ^ s3;
                        s3_nx    = s2;
                        s2_nx    = s1;
                        s1_nx    = fb;
                        cnt_nx   = cnt + 16'd1;
                        phase_nx = 1'b1;
                    end
                end else begin
                    out_nx   = sym(par);
                    valid_nx = 1'b1;
                    phase_nx = 1'b0;
                    // counter holds bits accepted so far, so it never has to pass blklen
                    if (cnt == len) begin
                        state_nx = TAIL;
                        tcnt_nx  = '0;
                    end
                end
            end
            TAIL: begin
                if (tcnt == 2'd3) begin
                    state_nx = IDLE;
                    phase_nx = 1'b0;
                end else if (!phase) begin
                    // u = s2^s3 drives the feedback to zero, flushing the trellis
                    out_nx   = sym(tu);
                    valid_nx = 1'b1;
                    par_nx   = s1 ^ s3;
                    s3_nx    = s2;
                    s2_nx    = s1;
                    s1_nx    = 1'b0;
                    phase_nx = 1'b1;
                end else begin
                    out_nx   = sym(par);
                    valid_nx = 1'b1;
                    last_nx  = (tcnt == 2'd2);
                    tcnt_nx  = tcnt + 2'd1;
                    phase_nx = 1'b0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_rsc_encoder.sv
// Self-checking bench for rsc_encoder: table-driven blocks, directed corner cases and random
// LTE-length blocks, all checked through a scoreboard fed by an independent shift-register model.
module tb_rsc_encoder;

    logic               clk = 1'b0;
    logic               rst, start, bit_in, valid_in;
    logic [15:0]        blklen;
    logic               ready_in, valid_out, last_out, busy;
    logic signed [15:0] out;

    always #5 clk = ~clk;

    rsc_encoder #(.AMP(16'sd64)) dut (
        .clk(clk), .rst(rst), .start(start), .blklen(blklen), .bit_in(bit_in),
        .valid_in(valid_in), .ready_in(ready_in), .out(out), .valid_out(valid_out),
        .last_out(last_out), .busy(busy)
    );

    typedef struct { logic signed [15:0] sym; logic last; } exp_t;
    typedef struct { int len; logic [31:0] pat; int gap; bit mid_start; int exp_nsym; } vec_t;

    exp_t  sb[$];
    logic  bits_q[$];
    int    log_q[$];
    int    checks = 0, errors = 0;
    int    nsym = 0, first_cyc = 0, last_cyc = 0;
    int    cyc = 0;
    bit    chk_busy_next = 1'b0;
    int    exp30[12] = '{-64, -64, 64, -64, 64, -64, -64, 64, -64, 64, -64, -64};
    vec_t  vecs[7];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic signed [15:0] amp(input logic b);
        return b ? -16'sd64 : 16'sd64;
    endfunction

    // Golden LTE constituent encoder: d[k] is the feedback node w delayed by k.
    task automatic model_block(input int len);
        logic [3:0] d;
        logic u, w, z;
        d = '0;
        for (int i = 0; i < len; i++) begin
            u = bits_q[i];
            w = u ^ d[2] ^ d[3];
            z = w ^ d[1] ^ d[3];
            sb.push_back('{amp(u), 1'b0});
            sb.push_back('{amp(z), 1'b0});
            d = {d[2], d[1], w, 1'b0};
        end
        for (int t = 0; t < 3; t++) begin
            u = d[2] ^ d[3];
            z = d[1] ^ d[3];
            sb.push_back('{amp(u), 1'b0});
            sb.push_back('{amp(z), (t == 2)});
            d = {d[2], d[1], 1'b0, 1'b0};
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        if (chk_busy_next) begin
            chk_busy_next = 1'b0;
            check("busy_after_last", busy, 0);
        end
        if (valid_out) begin
            if (sb.size() == 0) begin
                check("unexpected_symbol", out, 0);
                check("unexpected_valid", valid_out, 0);
            end else begin
                e = sb.pop_front();
                check("symbol", out, e.sym);
                check("last_out", last_out, e.last);
            end
            if (nsym % 2 == 0) check("ready_in_parity_slot", ready_in, 0);
            if (nsym == 0) first_cyc = cyc;
            last_cyc = cyc;
            nsym++;
            log_q.push_back(int'(out));
            if (last_out) chk_busy_next = 1'b1;
        end
    end

    task automatic send_bit(input logic b, output bit ok);
        bit_in   = b;
        valid_in = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (ready_in) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        valid_in = 1'b0;
        bit_in   = 1'($urandom);
        if (!ok) check("accept_timeout", 0, 1);
    endtask

    task automatic send_block(input int len, input int gap, input bit mid_start, input int exp_nsym);
        bit ok;
        nsym = 0;
        log_q.delete();
        model_block(len);
        start = 1'b1; blklen = 16'(len);
        @(posedge clk); #1;
        start = 1'b0; blklen = 16'(len + 7);
        for (int i = 0; i < len; i++) begin
            send_bit(bits_q[i], ok);
            if (!ok) break;
            for (int j = 0; j < gap; j++) begin
                if (mid_start && j == 0) start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
            end
        end
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!busy) begin ok = 1'b1; break; end
        end
        if (!ok) check("busy_timeout", 0, 1);
        @(posedge clk); #1;
        check("symbol_count", nsym, exp_nsym);
        check("scoreboard_empty", sb.size(), 0);
        if (gap == 0) check("contiguous_span", last_cyc - first_cyc, exp_nsym - 1);
        sb.delete();
    endtask

    task automatic load_pat(input int len, input logic [31:0] pat);
        bits_q.delete();
        for (int i = 0; i < len; i++) bits_q.push_back(pat[i]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        int len, gap;
        vecs[0] = '{3,  32'h1,    0, 1'b0, 12};
        vecs[1] = '{4,  32'h0,    0, 1'b0, 14};
        vecs[2] = '{3,  32'h1,    3, 1'b0, 12};
        vecs[3] = '{5,  32'h16,   1, 1'b1, 16};
        vecs[4] = '{1,  32'h1,    0, 1'b0, 8};
        vecs[5] = '{1,  32'h0,    2, 1'b1, 8};
        vecs[6] = '{16, 32'hA5C3, 0, 1'b0, 38};

        rst = 1'b1; start = 1'b1; blklen = 16'd5; bit_in = 1'b1; valid_in = 1'b1;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        check("rst_out", out, 0);
        check("rst_valid_out", valid_out, 0);
        check("rst_last_out", last_out, 0);
        check("rst_ready_in", ready_in, 0);
        check("rst_busy", busy, 0);
        start = 1'b0; valid_in = 1'b0; bit_in = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;

        for (int v = 0; v < 7; v++) begin
            load_pat(vecs[v].len, vecs[v].pat);
            send_block(vecs[v].len, vecs[v].gap, vecs[v].mid_start, vecs[v].exp_nsym);
            if (v == 0 || v == 2)
                for (int i = 0; i < 12; i++) check("ref_sequence", log_q[i], exp30[i]);
        end

        // start with zero length in IDLE must not launch a block
        start = 1'b1; blklen = 16'd0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("zero_len_busy", busy, 0);
            check("zero_len_valid_out", valid_out, 0);
        end
        @(posedge clk); #1;

        // reset right after the second accepted bit of an 8-bit block
        load_pat(8, 32'hB7);
        model_block(8);
        start = 1'b1; blklen = 16'd8;
        @(posedge clk); #1;
        start = 1'b0;
        send_bit(1'b1, ok);
        send_bit(1'b1, ok);
        rst = 1'b1; start = 1'b1; valid_in = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0; valid_in = 1'b0;
        sb.delete();
        @(negedge clk);
        check("abort_out", out, 0);
        check("abort_valid_out", valid_out, 0);
        check("abort_last_out", last_out, 0);
        check("abort_ready_in", ready_in, 0);
        check("abort_busy", busy, 0);
        @(posedge clk); #1;
        chk_busy_next = 1'b0;
        load_pat(3, 32'h1);
        send_block(3, 0, 1'b0, 12);
        for (int i = 0; i < 12; i++) check("post_abort_sequence", log_q[i], exp30[i]);

        // random blocks, including the largest LTE block size
        for (int r = 0; r < 4; r++) begin
            len = (r == 0) ? 6144 : int'($urandom_range(1, 300));
            gap = (r == 0) ? 0 : int'($urandom_range(0, 2));
            bits_q.delete();
            for (int i = 0; i < len; i++) bits_q.push_back(1'($urandom));
            send_block(len, gap, r[0], 2 * len + 6);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
